uap_uart_tx: RTL and testbench

//  UART transmitter for the uartprobe: serialises response bytes from the probe

---
 rtl/uap_pkg.sv | 14 +
 rtl/uap_fifo.sv | 57 +++++
 rtl/uap_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uap_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uap_pkg.sv
// Shared types and constants for the uartprobe serial datapaths.
package uap_pkg;

   localparam int UAP_BYTE_W      = 8;
   localparam int UAP_DEFAULT_CPB = 868;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uap_tx_state_t;

endpackage

// File: rtl/uap_fifo.sv
// Synchronous FIFO with occupancy count; shared by the TX and RX paths.
// Read data is the head entry, valid whenever empty_o is low.
module uap_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uap_uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits, fed from a byte FIFO.
// Frames are sent back to back with no idle gap while the FIFO holds data.
module uap_uart_tx
   import uap_pkg::*;
#(
   parameter int  CYCLES_PER_BIT = UAP_DEFAULT_CPB,
   parameter int  FIFO_DEPTH     = 4,
   parameter int  STOP_BITS      = 1,
   localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [UAP_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  uart_tx,
   output logic                  busy,
   output logic [CNT_W-1:0]      fifo_count
);

   localparam int          TW         = $clog2(CYCLES_PER_BIT);
   localparam logic [TW-1:0] BIT_RELOAD = TW'(CYCLES_PER_BIT - 1);
   localparam logic        STOP_LAST  = (STOP_BITS == 2);

   if (CYCLES_PER_BIT < 2) begin : g_bad_cpb
      $error("uap_uart_tx: CYCLES_PER_BIT must be >= 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uap_uart_tx: FIFO_DEPTH must be a power of two >= 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uap_uart_tx: STOP_BITS must be 1 or 2");
   end

   uap_tx_state_t         state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic                  stop_idx_q, stop_idx_d;
   logic [UAP_BYTE_W-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic [UAP_BYTE_W-1:0] fifo_rd_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_cnt;
   logic                  bit_done;

   // No fall-through: a full FIFO refuses a push even if it pops this cycle.
   assign tx_ready  = !fifo_full && !reset;
   assign fifo_push = tx_valid && tx_ready;
   assign bit_done  = (timer_q == '0);

   uap_fifo #(
      .WIDTH (UAP_BYTE_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (fifo_push),
      .wr_data_i (tx_data),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_cnt)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      fifo_pop   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rd_data;
               tx_d     = 1'b0;
               timer_d  = BIT_RELOAD;
               state_d  = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_d      = shift_q[0];
               timer_d   = BIT_RELOAD;
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               timer_d = BIT_RELOAD;
               if (bit_idx_q == 3'd7) begin
                  tx_d       = 1'b1;
                  stop_idx_d = 1'b0;
                  state_d    = STOP;
               end else begin
                  // shift_q[0] is the bit on the wire, so shift_q[1] is next.
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               if (stop_idx_q == STOP_LAST) begin
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     shift_d  = fifo_rd_data;
                     tx_d     = 1'b0;
                     timer_d  = BIT_RELOAD;
                     state_d  = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  stop_idx_d = 1'b1;
                  timer_d    = BIT_RELOAD;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

   assign uart_tx    = tx_q;
   assign busy       = (state_q != IDLE) || (fifo_cnt != '0);
   assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_uap_uart_tx.sv
// Bench for uap_uart_tx: frame-position reference model plus directed checks.
module tb_uap_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FL    = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_valid2 = 1'b0;

   logic       tx_ready, uart_tx, busy;
   logic [2:0] fifo_count;
   logic       tx_ready2, uart_tx2, busy2;
   logic [2:0] fifo_count2;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   uap_uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count));

   uap_uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid2),
      .tx_ready(tx_ready2), .uart_tx(uart_tx2), .busy(busy2), .fifo_count(fifo_count2));

   // Model: a byte queue and the position within the frame currently on the wire.
   logic [7:0] mq[$];
   bit         m_act = 1'b0;
   int         m_t = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_acc = 1'b0;
   int         m_pre;
   bit         m_push;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_act = 1'b0;
         m_t   = 0;
         m_acc = 1'b0;
      end else begin
         m_pre  = mq.size();
         m_push = tx_valid && (m_pre < DEPTH);
         m_acc  = m_push;
         if (m_act) begin
            m_t++;
            if (m_t == FL) m_act = 1'b0;
         end
         if (!m_act && m_pre > 0) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_t    = 0;
         end
         if (m_push) mq.push_back(tx_data);
      end
   end

   // {uart_tx, tx_ready, busy, fifo_count}
   function automatic logic [5:0] exp_vec();
      logic line;
      int   k;
      line = 1'b1;
      if (m_act) begin
         k = m_t / CPB;
         if (k == 0) line = 1'b0;
         else if (k <= 8) line = m_byte[k-1];
      end
      return {line, (!reset && (mq.size() < DEPTH)), (m_act || (mq.size() != 0)), 3'(mq.size())};
   endfunction

   wire [5:0] dut_vec = {uart_tx, tx_ready, busy, fifo_count};

   task automatic test_reset();
      reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         total_cnt++;
         if (dut_vec !== 6'b1_0_0_000) $display("FAIL reset_state s=%0d got %b want %b", s, dut_vec, 6'b1_0_0_000);
         else pass_cnt++;
      end
      tx_valid = 1'b0;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (tx_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", tx_ready);
      else pass_cnt++;
   endtask

   task automatic test_single_55();
      logic [49:0] cap, want;
      logic [49:0] bz;
      @(negedge clk);
      tx_data = 8'h55; tx_valid = 1'b1;
      for (int s = 0; s < 50; s++) begin
         @(negedge clk);
         if (s == 0) tx_valid = 1'b0;
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL single_55 s=%0d got %b want %b", s, dut_vec, exp_vec());
         else pass_cnt++;
         cap[s] = uart_tx;
         bz[s]  = busy;
         want[s] = (s == 0 || s > 40) ? 1'b1 : 1'(((s - 1) / CPB) % 2);
      end
      total_cnt++;
      if (cap !== want) $display("FAIL single_55_wave got %b want %b", cap, want);
      else pass_cnt++;
      total_cnt++;
      if (bz[40] !== 1'b1 || bz[41] !== 1'b0) $display("FAIL single_55_busy_fall got %b%b want 10", bz[40], bz[41]);
      else pass_cnt++;
   endtask

   task automatic test_fill();
      logic [7:0] bytes [6];
      int idx, nhs;
      int hs_cyc [6];
      for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
      idx = 0; nhs = 0;
      @(negedge clk);
      tx_valid = 1'b1; tx_data = bytes[0];
      for (int c = 0; c < 320; c++) begin
         if (tx_valid && tx_ready && nhs < 6) begin
            hs_cyc[nhs] = c;
            nhs++;
         end
         @(negedge clk);
         if (m_acc) idx++;
         if (idx >= 6) tx_valid = 1'b0;
         else tx_data = bytes[idx];
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL fill c=%0d got %b want %b", c, dut_vec, exp_vec());
         else pass_cnt++;
      end
      tx_valid = 1'b0;
      total_cnt++;
      if (nhs != 6) $display("FAIL fill_handshakes got %0d want 6", nhs);
      else begin
         pass_cnt++;
         total_cnt++;
         if (hs_cyc[4] - hs_cyc[0] != 4) $display("FAIL fill_consecutive got %0d want 4", hs_cyc[4] - hs_cyc[0]);
         else pass_cnt++;
         total_cnt++;
         if (hs_cyc[5] - hs_cyc[0] != FL + 2) $display("FAIL fill_sixth got %0d want %0d", hs_cyc[5] - hs_cyc[0], FL + 2);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic [99:0] cap;
      int a, b;
      @(negedge clk);
      tx_data = 8'h00; tx_valid = 1'b1;
      for (int s = 0; s < 100; s++) begin
         @(negedge clk);
         if (s == 0) tx_data = 8'hFF;
         if (s == 1) tx_valid = 1'b0;
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL b2b s=%0d got %b want %b", s, dut_vec, exp_vec());
         else pass_cnt++;
         cap[s] = uart_tx;
      end
      a = -1; b = -1;
      for (int s = 0; s < 100; s++) if (a < 0 && cap[s] == 1'b0) a = s;
      for (int s = 1; s < 100; s++) if (a >= 0 && b < 0 && s > a && cap[s-1] == 1'b1 && cap[s] == 1'b0) b = s;
      total_cnt++;
      if (a < 0 || b - a != FL) $display("FAIL b2b_gap got %0d want %0d", b - a, FL);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [10:0] frame;
      logic [39:0] cap, want;
      bit hit;
      @(negedge clk);
      tx_data = 8'hC3; tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h3C;
      @(negedge clk);
      tx_valid = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL rmid_pre c=%0d got %b want %b", c, dut_vec, exp_vec());
         else pass_cnt++;
         if (m_act && (m_t / CPB) == 4) hit = 1'b1;
         else @(negedge clk);
      end
      total_cnt++;
      if (!hit) $display("FAIL rmid_wait timeout got 0 want 1");
      else pass_cnt++;
      reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h99;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         total_cnt++;
         if ({uart_tx, tx_ready, fifo_count} !== 5'b1_0_000)
            $display("FAIL rmid_reset s=%0d got %b want %b", s, {uart_tx, tx_ready, fifo_count}, 5'b1_0_000);
         else pass_cnt++;
      end
      reset = 1'b0; tx_valid = 1'b0;
      @(negedge clk);
      tx_data = 8'hA5; tx_valid = 1'b1;
      frame = {2'b11, 8'hA5, 1'b0};
      for (int s = 0; s < 50; s++) begin
         @(negedge clk);
         if (s == 0) tx_valid = 1'b0;
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL rmid_post s=%0d got %b want %b", s, dut_vec, exp_vec());
         else pass_cnt++;
         if (s >= 1 && s <= 40) begin
            cap[s-1]  = uart_tx;
            want[s-1] = frame[(s - 1) / CPB];
         end
      end
      total_cnt++;
      if (cap !== want) $display("FAIL rmid_a5_frame got %b want %b", cap, want);
      else pass_cnt++;
   endtask

   task automatic test_stall_random();
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         tx_valid = 1'($urandom_range(0, 1));
         tx_data  = 8'($urandom);
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL stall c=%0d got %b want %b", c, dut_vec, exp_vec());
         else pass_cnt++;
      end
      tx_valid = 1'b0;
      for (int c = 0; c < 250; c++) begin
         @(negedge clk);
         total_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL drain c=%0d got %b want %b", c, dut_vec, exp_vec());
         else pass_cnt++;
      end
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL drain_idle busy got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_stop2();
      logic [11:0] frame;
      logic [1:0]  want;
      frame = {3'b111, 8'h81, 1'b0};
      @(negedge clk);
      tx_data = 8'h81; tx_valid2 = 1'b1;
      for (int s = 0; s < 52; s++) begin
         @(negedge clk);
         if (s == 0) tx_valid2 = 1'b0;
         if (s == 0) want = 2'b11;
         else if (s <= 11 * CPB) want = {frame[(s - 1) / CPB], 1'b1};
         else want = 2'b10;
         total_cnt++;
         if ({uart_tx2, busy2} !== want) $display("FAIL stop2 s=%0d got %b want %b", s, {uart_tx2, busy2}, want);
         else pass_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_55();
      test_fill();
      test_back_to_back();
      test_reset_mid();
      test_stall_random();
      test_stop2();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
